// File: rtl/reg_des.sv
// reg_des: serial-in / serial-out shift register of DEPTH stages with a
// saturating fill counter. The optional parallel tap of every stage is
// enabled by defining REG_DES_PARALLEL_OUT_EN.
module reg_des #(
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in,
    output logic             data_out,
    output logic             filled
`ifdef REG_DES_PARALLEL_OUT_EN
    ,
    output logic [DEPTH-1:0] parallel_out
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0] stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filled_q, filled_d;

    // Next state: shift toward the output; the counter saturates at DEPTH.
    // The loop form keeps DEPTH=1 legal, where it reduces to a single flop.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = data_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        cnt_d    = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
        filled_d = (cnt_d == CNT_FULL);
    end

    // State registers. Reset takes priority over the data sampled on that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q  <= '0;
            cnt_q    <= '0;
            filled_q <= 1'b0;
        end else begin
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            filled_q <= filled_d;
        end
    end

    assign data_out = stage_q[DEPTH-1];
    assign filled   = filled_q;

`ifdef REG_DES_PARALLEL_OUT_EN
    assign parallel_out = stage_q;
`endif

endmodule

// File: tb/tb_reg_des.sv
// Directed bench for reg_des: a DEPTH=4 instance for the main scenarios and
// a DEPTH=1 instance for the degenerate single-flop case.
module tb_reg_des;

    logic clock = 1'b0;
    logic reset, data_in, data_out, filled;
    logic reset1, data_in1, data_out1, filled1;
`ifdef REG_DES_PARALLEL_OUT_EN
    logic [3:0] parallel_out;
    logic [0:0] parallel_out1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    reg_des #(.DEPTH(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .filled   (filled)
`ifdef REG_DES_PARALLEL_OUT_EN
        ,
        .parallel_out (parallel_out)
`endif
    );

    reg_des #(.DEPTH(1)) dut1 (
        .clock    (clock),
        .reset    (reset1),
        .data_in  (data_in1),
        .data_out (data_out1),
        .filled   (filled1)
`ifdef REG_DES_PARALLEL_OUT_EN
        ,
        .parallel_out (parallel_out1)
`endif
    );

    // Advance one rising edge, then settle to mid-cycle for sampling.
    task automatic tick();
        @(posedge clock);
        #5;
    endtask

    task automatic test_reset();
        reset = 1'b1; data_in = 1'b1;
        tick();
        checks++;
        if (data_out !== 1'b0) begin
            failures++; $display("FAIL reset_data_out got=%b exp=0", data_out);
        end
        checks++;
        if (filled !== 1'b0) begin
            failures++; $display("FAIL reset_filled got=%b exp=0", filled);
        end
`ifdef REG_DES_PARALLEL_OUT_EN
        checks++;
        if (parallel_out !== 4'b0000) begin
            failures++; $display("FAIL reset_parallel got=%b exp=0000", parallel_out);
        end
`endif
    endtask

    task automatic test_fill_ones();
        logic [3:0] exp_out    = 4'b1000;   // index = edge number 0..3
        logic [3:0] exp_filled = 4'b1000;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_in = 1'b1;
            tick();
            checks++;
            if (data_out !== exp_out[k]) begin
                failures++; $display("FAIL fill_out[%0d] got=%b exp=%b", k, data_out, exp_out[k]);
            end
            checks++;
            if (filled !== exp_filled[k]) begin
                failures++; $display("FAIL fill_filled[%0d] got=%b exp=%b", k, filled, exp_filled[k]);
            end
        end
    endtask

    task automatic test_drain_zeros();
        logic [5:0] exp_out = 6'b000111;
        for (int k = 0; k < 6; k++) begin
            data_in = 1'b0;
            tick();
            checks++;
            if (data_out !== exp_out[k]) begin
                failures++; $display("FAIL drain_out[%0d] got=%b exp=%b", k, data_out, exp_out[k]);
            end
            checks++;
            if (filled !== 1'b1) begin
                failures++; $display("FAIL drain_filled[%0d] got=%b exp=1", k, filled);
            end
        end
    endtask

    // Register is all zeros here. Output after edge k equals input from edge k-3.
    task automatic test_pattern();
        logic [11:0] din_seq = 12'b0000_0100_1101; // bit k = input at edge k: 1,0,1,1,0,0,1,0,0,0,0,0
        logic [11:0] exp_seq = 12'b0010_0110_1000; // 0,0,0,1,0,1,1,0,0,1,0,0
        for (int k = 0; k < 12; k++) begin
            data_in = din_seq[k];
            tick();
            checks++;
            if (data_out !== exp_seq[k]) begin
                failures++; $display("FAIL pattern_out[%0d] got=%b exp=%b", k, data_out, exp_seq[k]);
            end
`ifdef REG_DES_PARALLEL_OUT_EN
            // After inputs 1,0,1,1: stage0 (newest)=1, stage1=1, stage2=0, stage3=1.
            if (k == 3) begin
                checks++;
                if (parallel_out !== 4'b1011) begin
                    failures++; $display("FAIL pattern_parallel got=%b exp=1011", parallel_out);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] exp_out    = 4'b1000;
        logic [3:0] exp_filled = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            data_in = 1'b1;
            tick();
        end
        checks++;
        if (data_out !== 1'b1 || filled !== 1'b1) begin
            failures++; $display("FAIL mid_loaded got=%b%b exp=11", data_out, filled);
        end
        reset = 1'b1; data_in = 1'b1;
        tick();
        checks++;
        if (data_out !== 1'b0 || filled !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%b%b exp=00", data_out, filled);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_in = 1'b1;
            tick();
            checks++;
            if (data_out !== exp_out[k] || filled !== exp_filled[k]) begin
                failures++;
                $display("FAIL mid_after[%0d] got=%b%b exp=%b%b", k, data_out, filled, exp_out[k], exp_filled[k]);
            end
        end
    endtask

    task automatic test_depth1();
        logic [3:0] din_seq = 4'b0110; // bit k = input at edge k: 0,1,1,0
        reset1 = 1'b1; data_in1 = 1'b1;
        tick();
        checks++;
        if (data_out1 !== 1'b0 || filled1 !== 1'b0) begin
            failures++; $display("FAIL d1_reset got=%b%b exp=00", data_out1, filled1);
        end
        reset1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_in1 = din_seq[k];
            tick();
            checks++;
            if (data_out1 !== din_seq[k]) begin
                failures++; $display("FAIL d1_out[%0d] got=%b exp=%b", k, data_out1, din_seq[k]);
            end
            checks++;
            if (filled1 !== 1'b1) begin
                failures++; $display("FAIL d1_filled[%0d] got=%b exp=1", k, filled1);
            end
        end
    endtask

    initial begin
        reset = 1'b1; data_in = 1'b0;
        reset1 = 1'b1; data_in1 = 1'b0;
        test_reset();
        test_fill_ones();
        test_drain_zeros();
        test_pattern();
        test_reset_midstream();
        test_depth1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
